// File: rtl/fir_cfg_sequencer.sv
// fir_cfg_sequencer: AXI-Lite master that configures the fir slave for one run
// (idle check, length, tap count, coefficients, ap_start) and then polls for ap_done.
module fir_cfg_sequencer #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_len,
  input  logic [31:0]            cmd_taps,
  input  logic                   coef_tvalid,
  input  logic [31:0]            coef_tdata,
  output logic                   coef_tready,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned K_W      = ($clog2(Tape_Num) > 5) ? $clog2(Tape_Num) : 5;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(32'h00);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAPN = pADDR_WIDTH'(32'h14);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_WR_LEN, S_WR_TAPN, S_WR_TAP, S_WR_START, S_POLL, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t           state;
  logic [31:0]      len_q;
  logic [K_W-1:0]   taps_q;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] rd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             ret_poll;

  // A write completes once each channel has either handshaked earlier or does so now.
  logic wr_fin_c;
  logic status_hit_c;
  logic unused_rdata;

  assign wr_fin_c     = (!awvalid || awready) && (!wvalid || wready);
  assign status_hit_c = (state == S_CHK) ? rdata[2] : rdata[1];
  assign unused_rdata = ^{rdata[pDATA_WIDTH-1:3], rdata[0]};

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      coef_tready <= 1'b0;
      awvalid     <= 1'b0;
      awaddr      <= '0;
      wvalid      <= 1'b0;
      wdata       <= '0;
      arvalid     <= 1'b0;
      araddr      <= '0;
      rready      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      len_q       <= '0;
      taps_q      <= '0;
      k           <= '0;
      rd_cnt      <= '0;
      gap_cnt     <= '0;
      ret_poll    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;

      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            len_q     <= cmd_len;
            taps_q    <= K_W'(cmd_taps);
            if (cmd_taps == 32'd0 || cmd_taps > 32'(Tape_Num)) begin
              state <= S_ERR;
            end else begin
              state   <= S_CHK;
              arvalid <= 1'b1;
              araddr  <= ADDR_CTRL;
              rd_cnt  <= '0;
            end
          end
        end

        // Status read shared by the idle check and the done poll.
        S_CHK, S_POLL: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
          if (rready && rvalid) begin
            rready <= 1'b0;
            if (status_hit_c) begin
              if (state == S_CHK) begin
                state   <= S_WR_LEN;
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                awaddr  <= ADDR_LEN;
                wdata   <= pDATA_WIDTH'(len_q);
              end else begin
                state <= S_DONE;
              end
            end else if (rd_cnt == CNT_W'(TIMEOUT - 1)) begin
              state <= S_ERR;
            end else begin
              rd_cnt   <= rd_cnt + CNT_W'(1);
              gap_cnt  <= '0;
              ret_poll <= (state == S_POLL);
              state    <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) begin
            state   <= ret_poll ? S_POLL : S_CHK;
            arvalid <= 1'b1;
            araddr  <= ADDR_CTRL;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        S_WR_LEN: begin
          if (wr_fin_c) begin
            state   <= S_WR_TAPN;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= ADDR_TAPN;
            wdata   <= pDATA_WIDTH'(taps_q);
          end
        end

        S_WR_TAPN: begin
          if (wr_fin_c) begin
            state       <= S_WR_TAP;
            k           <= '0;
            coef_tready <= 1'b1;
          end
        end

        // Alternates between accepting one coefficient and writing it to tap k.
        S_WR_TAP: begin
          if (coef_tready) begin
            if (coef_tvalid) begin
              coef_tready <= 1'b0;
              awvalid     <= 1'b1;
              wvalid      <= 1'b1;
              awaddr      <= pADDR_WIDTH'(32'h80 + (32'(k) << 2));
              wdata       <= pDATA_WIDTH'(coef_tdata);
            end
          end else if (wr_fin_c) begin
            if (k == taps_q - K_W'(1)) begin
              state   <= S_WR_START;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= ADDR_CTRL;
              wdata   <= pDATA_WIDTH'(32'd1);
            end else begin
              k           <= k + K_W'(1);
              coef_tready <= 1'b1;
            end
          end
        end

        S_WR_START: begin
          if (wr_fin_c) begin
            state   <= S_POLL;
            arvalid <= 1'b1;
            araddr  <= ADDR_CTRL;
            rd_cnt  <= '0;
          end
        end

        S_DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        S_ERR: begin
          err       <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// tb_fir_cfg_sequencer: AXI-Lite slave/status model plus directed and randomized runs,
// compared against the expected register-write list and read counts of each command.
module tb_fir_cfg_sequencer;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMX = 11;
  localparam int unsigned GAP = 4;
  localparam int unsigned TMO = 64;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_len = '0;
  logic [31:0]   cmd_taps = '0;
  logic          coef_tvalid = 1'b0;
  logic [31:0]   coef_tdata = '0;
  logic          coef_tready;
  logic          awvalid, wvalid, arvalid, rready;
  logic          awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic          busy, done, err;

  fir_cfg_sequencer #(
    .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(TMX), .POLL_GAP(GAP), .TIMEOUT(TMO)
  ) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_taps(cmd_taps),
    .coef_tvalid(coef_tvalid), .coef_tdata(coef_tdata), .coef_tready(coef_tready),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 axis_clk = ~axis_clk;

  int tests = 0;
  int fails = 0;

  // slave behaviour knobs
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int idle_after = 0, done_after = 0;
  bit never_done = 1'b0, coef_stall = 1'b0;

  // slave state and observations
  int aw_cnt, w_cnt, ar_cnt, r_cnt;
  bit r_pending, r_fire, c_fire, started, last_r_ok;
  logic [31:0] r_resp;
  logic [AW-1:0] aw_q[$];
  logic [DW-1:0] w_q[$];
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  logic [31:0]   coef_q[$];
  logic [31:0]   coef_src[$];
  int chk_reads, poll_reads, done_cnt, err_cnt, coefs_used, bus_cycles;
  int stab_viol, gap_viol, proto_viol, cyc, last_r_cyc;
  logic prev_awvalid, prev_wvalid, prev_arvalid, prev_aw_fire, prev_w_fire, prev_ar_fire;
  logic [AW-1:0] prev_awaddr;
  logic [DW-1:0] prev_wdata;
  logic [AW-1:0] sl_a;
  logic [DW-1:0] sl_d;
  logic [31:0]   sl_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge axis_clk);
    #1;
  endtask

  // Slave, coefficient source and protocol monitor; a handshake seen here fires on the next rising edge.
  always @(negedge axis_clk) begin
    if (!axis_rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
      coef_tvalid = 1'b0; coef_tdata = '0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      r_pending = 1'b0; r_fire = 1'b0; c_fire = 1'b0; last_r_ok = 1'b0;
      prev_awvalid = 1'b0; prev_wvalid = 1'b0; prev_arvalid = 1'b0;
      prev_aw_fire = 1'b0; prev_w_fire = 1'b0; prev_ar_fire = 1'b0;
      prev_awaddr = '0; prev_wdata = '0;
      aw_q.delete(); w_q.delete(); coef_q.delete();
    end else begin
      cyc++;
      if (prev_awvalid && !prev_aw_fire && (!awvalid || awaddr != prev_awaddr)) stab_viol++;
      if (prev_wvalid && !prev_w_fire && (!wvalid || wdata != prev_wdata)) stab_viol++;
      if ((awvalid && (!prev_awvalid || prev_aw_fire)) != (wvalid && (!prev_wvalid || prev_w_fire)))
        proto_viol++;

      awready = 1'b0;
      if (awvalid) begin
        if (aw_cnt >= aw_dly) begin awready = 1'b1; aw_cnt = 0; end else aw_cnt++;
      end
      wready = 1'b0;
      if (wvalid) begin
        if (w_cnt >= w_dly) begin wready = 1'b1; w_cnt = 0; end else w_cnt++;
      end
      if (awvalid && awready) aw_q.push_back(awaddr);
      if (wvalid && wready) w_q.push_back(wdata);
      while (aw_q.size() > 0 && w_q.size() > 0) begin
        sl_a = aw_q.pop_front();
        sl_d = w_q.pop_front();
        log_addr.push_back(sl_a);
        log_data.push_back(sl_d);
        if (sl_a == '0 && sl_d == 32'd1) started = 1'b1;
      end

      if (r_fire) begin rvalid = 1'b0; r_fire = 1'b0; end
      if (r_pending && !rvalid) begin
        if (r_cnt >= r_dly) begin rvalid = 1'b1; rdata = r_resp; r_pending = 1'b0; end
        else r_cnt++;
      end
      if (prev_arvalid && !prev_ar_fire && !arvalid) proto_viol++;
      if (arvalid && rready) proto_viol++;
      if (awvalid) last_r_ok = 1'b0;
      if (arvalid && (!prev_arvalid || prev_ar_fire) && last_r_ok && (cyc - last_r_cyc - 1) != GAP)
        gap_viol++;
      arready = 1'b0;
      if (arvalid) begin
        if (ar_cnt >= ar_dly) begin arready = 1'b1; ar_cnt = 0; end else ar_cnt++;
      end
      if (arvalid && arready) begin
        if (araddr != '0) proto_viol++;
        r_resp = $urandom & 32'hFFFF_FFF9;
        if (!started) begin
          r_resp[1] = 1'($urandom_range(0, 1));
          r_resp[2] = (chk_reads >= idle_after);
          chk_reads++;
        end else begin
          r_resp[2] = 1'($urandom_range(0, 1));
          r_resp[1] = !never_done && (poll_reads >= done_after);
          poll_reads++;
        end
        r_pending = 1'b1;
        r_cnt = 0;
      end
      if (rvalid && rready) begin r_fire = 1'b1; last_r_cyc = cyc; last_r_ok = 1'b1; end

      if (c_fire) begin sl_c = coef_q.pop_front(); c_fire = 1'b0; coefs_used++; coef_tvalid = 1'b0; end
      if (coef_q.size() == 0) coef_tvalid = 1'b0;
      else if (!coef_tvalid && (!coef_stall || $urandom_range(0, 2) == 0)) coef_tvalid = 1'b1;
      if (coef_tvalid) coef_tdata = coef_q[0];
      if (coef_tready && (awvalid || wvalid)) proto_viol++;
      if (coef_tvalid && coef_tready) c_fire = 1'b1;

      if (done) done_cnt++;
      if (err) err_cnt++;
      if (awvalid || wvalid || arvalid || rready || coef_tready) bus_cycles++;
      if (cmd_ready && busy) proto_viol++;

      prev_awvalid = awvalid; prev_wvalid = wvalid; prev_arvalid = arvalid;
      prev_aw_fire = awvalid && awready; prev_w_fire = wvalid && wready;
      prev_ar_fire = arvalid && arready;
      prev_awaddr = awaddr; prev_wdata = wdata;
    end
  end

  task automatic clear_obs();
    log_addr.delete(); log_data.delete();
    chk_reads = 0; poll_reads = 0; done_cnt = 0; err_cnt = 0; coefs_used = 0; bus_cycles = 0;
    stab_viol = 0; gap_viol = 0; proto_viol = 0;
    started = 1'b0; last_r_ok = 1'b0;
    coef_q = coef_src;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {cmd_ready, coef_tready, awvalid, wvalid, arvalid, rready, busy, done, err}, 0);
    check({tag, "_addr"}, {awaddr, araddr}, 0);
    check({tag, "_wdata"}, wdata, 0);
  endtask

  task automatic run_cmd(input string name, input logic [31:0] len, input logic [31:0] taps,
                         input bit spam);
    bit bad, acc, exp_done;
    int exp_chk, exp_poll, waited;
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];

    // Expected outcome straight from the command and the slave's status script.
    bad = (taps == 0) || (taps > TMX);
    if (!bad) begin
      exp_addr.push_back(AW'(32'h10)); exp_data.push_back(len);
      exp_addr.push_back(AW'(32'h14)); exp_data.push_back(taps);
      for (int i = 0; i < int'(taps); i++) begin
        exp_addr.push_back(AW'(32'h80 + 4 * i));
        exp_data.push_back(coef_src[i]);
      end
      exp_addr.push_back(AW'(32'h00)); exp_data.push_back(32'd1);
    end
    exp_done = !bad && !never_done;
    exp_chk  = bad ? 0 : idle_after + 1;
    exp_poll = bad ? 0 : (never_done ? TMO : done_after + 1);

    clear_obs();
    cmd_valid = 1'b1; cmd_len = len; cmd_taps = taps;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = cmd_ready;
      step();
    end
    check({name, "_accept"}, acc, 1);
    if (spam) cmd_taps = 32'd0;
    else cmd_valid = 1'b0;
    check({name, "_busy_after_accept"}, busy, 1);
    if (bad) begin
      step();
      check({name, "_err_next"}, {err, busy}, 2'b10);
    end
    waited = 0;
    while (done_cnt + err_cnt == 0 && waited < 3000) begin
      step();
      waited++;
    end
    cmd_valid = 1'b0;
    check({name, "_finished_in_time"}, waited < 3000, 1);
    repeat (3) step();

    check({name, "_done_pulses"}, done_cnt, exp_done ? 1 : 0);
    check({name, "_err_pulses"}, err_cnt, exp_done ? 0 : 1);
    check({name, "_idle_after"}, {busy, cmd_ready}, 2'b01);
    check({name, "_nwrites"}, log_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", name, i), log_addr[i], exp_addr[i]);
      check($sformatf("%s_wr%0d_data", name, i), log_data[i], exp_data[i]);
    end
    check({name, "_dangling_halves"}, aw_q.size() + w_q.size(), 0);
    check({name, "_chk_reads"}, chk_reads, exp_chk);
    check({name, "_poll_reads"}, poll_reads, exp_poll);
    check({name, "_coefs_used"}, coefs_used, bad ? 0 : taps);
    check({name, "_stability"}, stab_viol, 0);
    check({name, "_read_spacing"}, gap_viol, 0);
    check({name, "_protocol"}, proto_viol, 0);
    if (bad) check({name, "_no_bus_activity"}, bus_cycles, 0);
  endtask

  task automatic rand_coefs(input int n);
    coef_src.delete();
    for (int i = 0; i < n; i++) coef_src.push_back($urandom);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int w;

    repeat (2) step();
    check_all_zero("reset");
    axis_rst_n = 1'b1;
    step();
    check("idle_cmd_ready", {cmd_ready, busy}, 2'b10);

    coef_src = '{32'h0, 32'hFFFF_FFF6, 32'hFFFF_FFF7, 32'd23, 32'd56, 32'd63,
                 32'd56, 32'd23, 32'hFFFF_FFF7, 32'hFFFF_FFF6, 32'h0};
    idle_after = 0; done_after = 49;
    run_cmd("main", 32'd600, 32'd11, 1'b0);

    aw_dly = 3; w_dly = 0; done_after = 2; rand_coefs(5);
    run_cmd("aw_late", 32'd123, 32'd5, 1'b0);
    aw_dly = 0;

    rand_coefs(12);
    run_cmd("taps0", 32'd50, 32'd0, 1'b0);
    run_cmd("taps12", 32'd50, 32'd12, 1'b0);

    idle_after = 5; done_after = 1; rand_coefs(3);
    run_cmd("chk_busy", 32'd9, 32'd3, 1'b0);
    idle_after = 0;

    never_done = 1'b1; rand_coefs(2);
    run_cmd("timeout", 32'd4, 32'd2, 1'b0);

    // Reset while waiting for the coefficient of tap 4.
    rand_coefs(11);
    clear_obs();
    cmd_valid = 1'b1; cmd_len = 32'd77; cmd_taps = 32'd11;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin acc = cmd_ready; step(); end
    cmd_valid = 1'b0;
    w = 0;
    while (log_addr.size() < 6 && w < 3000) begin step(); w++; end
    check("rst_reach_tap4", w < 3000, 1);
    step();
    check("rst_pre_state", {coef_tready, awvalid, coefs_used[3:0]}, {2'b10, 4'd4});
    axis_rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    repeat (2) step();
    axis_rst_n = 1'b1;
    never_done = 1'b0; done_after = 3; rand_coefs(4);
    run_cmd("after_rst", 32'd31, 32'd4, 1'b0);

    done_after = 2; rand_coefs(6);
    run_cmd("cmd_while_busy", 32'd64, 32'd6, 1'b1);

    coef_stall = 1'b1;
    for (int r = 0; r < 6; r++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      idle_after = $urandom_range(0, 3); done_after = $urandom_range(0, 8);
      w = $urandom_range(1, TMX);
      rand_coefs(w);
      run_cmd($sformatf("rand%0d", r), $urandom, 32'(w), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
